// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the dot-product sequencer that drives
// a single start/done 8x8 multiply unit.
package mac_seq_pkg;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/mac_opnd_buf.sv
// Two operand banks (A and B) sharing one write port, both read
// combinationally at the same element index.
module mac_opnd_buf
  import mac_seq_pkg::*;
#(
  parameter int N_MAX = 16,
  parameter int AW    = $clog2(N_MAX)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [AW-1:0]     wr_addr,
  input  logic [OPND_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [OPND_W-1:0] rd_a,
  output logic [OPND_W-1:0] rd_b
);

  logic [OPND_W-1:0] bank_a_q [N_MAX];
  logic [OPND_W-1:0] bank_b_q [N_MAX];

  // Contents are deliberately left unreset; the host loads them before use.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_sel) bank_a_q[wr_addr] <= wr_data;
    if (wr_en &&  wr_sel) bank_b_q[wr_addr] <= wr_data;
  end

  assign rd_a = bank_a_q[rd_addr];
  assign rd_b = bank_b_q[rd_addr];

endmodule

// File: rtl/mac_sequencer.sv
// Issues one multiply request per element pair, accumulates the products
// and returns the dot product (or a timed-out partial sum) over valid/ready.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_MAX   = 16,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(N_MAX)-1:0] wr_addr,
  input  logic [OPND_W-1:0]        wr_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(N_MAX):0]   cmd_len,
  output logic                     mul_start,
  output logic [OPND_W-1:0]        mul_a,
  output logic [OPND_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]        mul_y,
  input  logic                     mul_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_data,
  output logic                     res_err,
  output logic                     busy
);

  localparam int AW = $clog2(N_MAX);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              mul_start_q, mul_start_d;
  logic [OPND_W-1:0] mul_a_q, mul_a_d;
  logic [OPND_W-1:0] mul_b_q, mul_b_d;
  logic              res_valid_q, res_valid_d;
  logic [ACC_W-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;

  logic [AW-1:0]     rd_addr;
  logic [OPND_W-1:0] rd_a, rd_b;
  logic [LW-1:0]     len_clamped;
  logic [ACC_W-1:0]  acc_sum;

  mac_opnd_buf #(.N_MAX(N_MAX), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && !busy_q),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // The operands are registered as the request is launched, so the read
  // index is the element about to be issued, not the one in flight.
  assign rd_addr     = (state_q == WAIT) ? idx_q[AW-1:0] + AW'(1) : '0;
  assign len_clamped = (cmd_len > LW'(N_MAX)) ? LW'(N_MAX) : cmd_len;
  assign acc_sum     = acc_q + ACC_W'(mul_y);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    acc_d       = acc_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d = len_clamped;
          idx_d = '0;
          acc_d = '0;
          err_d = 1'b0;
          if (len_clamped == '0) begin
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_err_d   = 1'b0;
          end else begin
            state_d     = ISSUE;
            mul_start_d = 1'b1;
            mul_a_d     = rd_a;
            mul_b_d     = rd_b;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mul_done) begin
          acc_d = acc_sum;
          idx_d = idx_q + LW'(1);
          if (idx_q == len_q - LW'(1)) begin
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_data_d  = acc_sum;
            res_err_d   = 1'b0;
          end else begin
            state_d     = ISSUE;
            mul_start_d = 1'b1;
            mul_a_d     = rd_a;
            mul_b_d     = rd_b;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
            err_d       = 1'b1;
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_data_d  = acc_q;
            res_err_d   = 1'b1;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          res_data_d  = '0;
          res_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed and randomized bench for mac_sequencer with a next-cycle
// multiplier responder that can be told to stop answering.
module tb_mac_sequencer;

  localparam int N_MAX   = 16;
  localparam int ACC_W   = 24;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_len;
  logic              mul_start;
  logic [7:0]        mul_a, mul_b;
  logic [15:0]       mul_y = '0;
  logic              mul_done;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [7:0]       ref_a [N_MAX];
  logic [7:0]       ref_b [N_MAX];
  logic [ACC_W-1:0] exp_q [$];

  // clock / reset
  always #5 clk = ~clk;

  mac_sequencer #(.N_MAX(N_MAX), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  // Multiplier model: answers the cycle after mul_start, but only for the
  // first stub_limit requests of a command.
  logic       pend = 1'b0;
  logic [7:0] pa = '0, pb = '0;
  logic       done_m = 1'b0;
  logic       spur_done = 1'b0;
  int         req_k = 0;
  int         stub_limit = 1000;

  assign mul_done = done_m | spur_done;

  always @(negedge clk) begin
    done_m = 1'b0;
    if (!busy) req_k = 0;
    if (pend && req_k <= stub_limit) begin
      done_m = 1'b1;
      mul_y  = 16'(pa) * 16'(pb);
    end
    if (mul_start) req_k++;
    pend = mul_start;
    pa   = mul_a;
    pb   = mul_b;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_mul_start"}, 32'(mul_start), 0);
    check({tag, "_mul_a"},     32'(mul_a), 0);
    check({tag, "_mul_b"},     32'(mul_b), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"},  32'(res_data), 0);
    check({tag, "_res_err"},   32'(res_err), 0);
  endtask

  // driver tasks
  task automatic write_elem(input bit sel, input int addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) ref_b[addr] = data; else ref_a[addr] = data;
  endtask

  task automatic run_cmd(input string tag, input int len, input int stub,
                         input int hold, input bit poke);
    int n, used, e_pulses, c, pulses;
    bit e_err, prev;
    int sum;
    logic [ACC_W-1:0] exp_data;
    n    = (len > N_MAX) ? N_MAX : len;
    e_err = (stub < n);
    used = e_err ? stub : n;
    sum  = 0;
    for (int i = 0; i < used; i++) sum += int'(ref_a[i]) * int'(ref_b[i]);
    exp_q.push_back(ACC_W'(sum));
    e_pulses = e_err ? stub + 1 : n;
    stub_limit = stub;
    if (poke) begin
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
    end
    check({tag, "_ready_pre"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_len = 5'(len);
    tick();
    cmd_valid = 1'b0;
    c = 1; pulses = 0; prev = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    while (!res_valid && c < 200) begin
      if (mul_start) begin
        pulses++;
        check({tag, "_b2b_start"}, 32'(prev), 0);
      end
      prev    = mul_start;
      wr_en   = poke && (c == 2 || c == 3);
      wr_sel  = (c == 3);
      wr_addr = 4'd0;
      wr_data = 8'hA5;
      tick();
      c++;
    end
    wr_en = 1'b0;
    exp_data = exp_q.pop_front();
    check({tag, "_res_valid_seen"}, 32'(res_valid), 1);
    if (res_valid) begin
      check({tag, "_res_data"}, 32'(res_data), 32'(exp_data));
      check({tag, "_res_err"},  32'(res_err), 32'(e_err));
      check({tag, "_pulses"},   32'(pulses), 32'(e_pulses));
      if (!e_err) check({tag, "_latency"}, 32'(c), 32'(2 * n + 1));
      for (int h = 0; h < hold; h++) begin
        tick();
        check({tag, "_hold_valid"}, 32'(res_valid), 1);
        check({tag, "_hold_data"},  32'(res_data), 32'(exp_data));
        check({tag, "_hold_err"},   32'(res_err), 32'(e_err));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_valid_after"}, 32'(res_valid), 0);
      check({tag, "_ready_after"}, 32'(cmd_ready), 1);
      check({tag, "_busy_after"},  32'(busy), 0);
    end
    stub_limit = 1000;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    cmd_valid = 1'b0; cmd_len = '0; res_ready = 1'b0;
    tick(); tick();
    reset_outputs_check("reset");
    rst = 1'b0;
    tick();

    // A = 1..4, B = 2 -> 20
    for (int i = 0; i < 4; i++) begin
      write_elem(1'b0, i, 8'(i + 1));
      write_elem(1'b1, i, 8'd2);
    end
    run_cmd("dot4", 4, 1000, 0, 1'b0);

    // full-length saturating operands, then an over-long command clamped to N_MAX
    for (int i = 0; i < N_MAX; i++) begin
      write_elem(1'b0, i, 8'hFF);
      write_elem(1'b1, i, 8'hFF);
    end
    run_cmd("full16", 16, 1000, 0, 1'b0);
    run_cmd("clamp20", 20, 1000, 1, 1'b0);

    run_cmd("len0", 0, 1000, 0, 1'b0);

    // multiplier stops answering after the first request; result held 5 cycles
    for (int i = 0; i < 4; i++) begin
      write_elem(1'b0, i, 8'(i + 3));
      write_elem(1'b1, i, 8'(7 * i + 5));
    end
    run_cmd("timeout", 4, 1, 5, 1'b0);

    // spurious done in IDLE and writes while busy must leave everything intact
    run_cmd("poke", 4, 1000, 2, 1'b1);
    run_cmd("after_poke", 4, 1000, 0, 1'b0);

    // reset while waiting on the multiplier
    cmd_valid = 1'b1; cmd_len = 5'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    reset_outputs_check("rst_wait");
    rst = 1'b0;
    tick();
    check("rst_wait_idle_ready", 32'(cmd_ready), 1);
    check("rst_wait_idle_valid", 32'(res_valid), 0);
    run_cmd("after_rst", 5, 1000, 0, 1'b0);

    // randomized operands and lengths
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N_MAX; i++) begin
        write_elem(1'b0, i, 8'($urandom_range(0, 255)));
        write_elem(1'b1, i, 8'($urandom_range(0, 255)));
      end
      run_cmd($sformatf("rand%0d", it), int'($urandom_range(0, 20)), 1000,
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
